// File: rtl/apbdma_xfer_ctrl_if.sv
// rtl/apbdma_xfer_ctrl_if.sv - APB master bundle driven by the DMA transfer sequencer
interface apbdma_xfer_ctrl_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    logic                   psel_o;
    logic                   penable_o;
    logic                   pwrite_o;
    logic [AddrWidth-1:0]   paddr_o;
    logic [DataWidth-1:0]   pwdata_o;
    logic [DataWidth/8-1:0] pstrb_o;
    logic                   pready_i;
    logic                   pslverr_i;
    logic [DataWidth-1:0]   prdata_i;

    modport master (
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
        input  pready_i, pslverr_i, prdata_i
    );

    modport slave (
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
        output pready_i, pslverr_i, prdata_i
    );
endinterface

// File: rtl/apbdma_xfer_ctrl.sv
// rtl/apbdma_xfer_ctrl.sv - APB DMA transfer sequencer: single-beat APB master between cfg regs and FIFOs
module apbdma_xfer_ctrl #(
    parameter int AddrWidth     = 32,
    parameter int MstDataWidth  = 32,
    parameter int NumBytesWidth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     rw_i,
    input  logic [AddrWidth-1:0]     start_addr_i,
    input  logic [NumBytesWidth-1:0] num_bytes_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    apbdma_xfer_ctrl_if.master       apb,
    output logic                     rfifo_push_o,
    output logic [MstDataWidth-1:0]  rfifo_data_o,
    input  logic                     rfifo_full_i,
    output logic                     wfifo_pop_o,
    input  logic [MstDataWidth-1:0]  wfifo_data_i,
    input  logic                     wfifo_empty_i
);
    localparam int BytesPerBeat = MstDataWidth / 8;
    localparam int BeatShift    = $clog2(BytesPerBeat);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SETUP, S_ACCESS} state_e;

    state_e                   state_q, state_d;
    logic                     start_q, armed_q, rw_q;
    logic                     busy_q, done_q, err_q;
    logic                     psel_q, penable_q, pwrite_q;
    logic [AddrWidth-1:0]     addr_q;
    logic [MstDataWidth-1:0]  pwdata_q;
    logic [BytesPerBeat-1:0]  pstrb_q;
    logic [NumBytesWidth-1:0] beats_q, launch_beats;
    logic                     launch, rw_eff, complete, last_beat;
    logic                     issue_eval, issue_go, psel_d;

    always_comb begin
        launch_beats = num_bytes_i >> BeatShift;
        // A level already high out of reset is not an edge: arm only after start_i is seen low.
        launch       = (state_q == S_IDLE) && start_i && !start_q && armed_q;
        rw_eff       = launch ? rw_i : rw_q;
        complete     = (state_q == S_ACCESS) && apb.pready_i;
        last_beat    = (beats_q == NumBytesWidth'(1));
        issue_eval   = (launch && (launch_beats != '0)) || (state_q == S_WAIT) ||
                       (complete && !apb.pslverr_i && !last_beat);
        issue_go     = issue_eval && (rw_eff ? !rfifo_full_i : !wfifo_empty_i);

        state_d = state_q;
        if (state_q == S_SETUP) begin
            state_d = S_ACCESS;
        end else if (issue_eval) begin
            state_d = issue_go ? S_SETUP : S_WAIT;
        end else if (complete) begin
            state_d = S_IDLE;
        end
        psel_d = (state_d == S_SETUP) || (state_d == S_ACCESS);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            armed_q   <= 1'b0;
            rw_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            addr_q    <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            beats_q   <= '0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_i;
            armed_q   <= armed_q | ~start_i;
            busy_q    <= (state_d != S_IDLE);
            psel_q    <= psel_d;
            penable_q <= (state_d == S_ACCESS);
            pwrite_q  <= psel_d && !rw_eff;
            pstrb_q   <= {BytesPerBeat{psel_d}};
            done_q    <= (launch && (launch_beats == '0)) ||
                         (complete && (apb.pslverr_i || last_beat));
            if (launch) begin
                rw_q    <= rw_i;
                addr_q  <= start_addr_i;
                beats_q <= launch_beats;
                err_q   <= 1'b0;
            end
            if (complete) begin
                if (apb.pslverr_i) begin
                    err_q <= 1'b1;
                end else begin
                    addr_q  <= addr_q + AddrWidth'(BytesPerBeat);
                    beats_q <= beats_q - NumBytesWidth'(1);
                end
            end
            if (wfifo_pop_o) begin
                pwdata_q <= wfifo_data_i;
            end
        end
    end

    // FIFO strobes are same-cycle handshakes; gate them so reset silences them immediately.
    assign wfifo_pop_o   = !rst_i && issue_go && !rw_eff;
    assign rfifo_push_o  = !rst_i && complete && !apb.pslverr_i && rw_q;
    assign rfifo_data_o  = apb.prdata_i;

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign apb.psel_o    = psel_q;
    assign apb.penable_o = penable_q;
    assign apb.pwrite_o  = pwrite_q;
    assign apb.paddr_o   = addr_q;
    assign apb.pwdata_o  = pwdata_q;
    assign apb.pstrb_o   = pstrb_q;
endmodule

// File: tb/tb_apbdma_xfer_ctrl.sv
// tb/tb_apbdma_xfer_ctrl.sv - scoreboard bench for the APB DMA transfer sequencer
module tb_apbdma_xfer_ctrl;
    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, rw_i;
    logic [31:0] start_addr_i;
    logic [7:0]  num_bytes_i;
    logic        busy_o, done_o, err_o;
    logic        rfifo_push_o, rfifo_full_i, wfifo_pop_o, wfifo_empty_i;
    logic [31:0] rfifo_data_o, wfifo_data_i;

    apbdma_xfer_ctrl_if #(.AddrWidth(32), .DataWidth(32)) apb ();

    apbdma_xfer_ctrl #(.AddrWidth(32), .MstDataWidth(32), .NumBytesWidth(8)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .rw_i         (rw_i),
        .start_addr_i (start_addr_i),
        .num_bytes_i  (num_bytes_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .apb          (apb),
        .rfifo_push_o (rfifo_push_o),
        .rfifo_data_o (rfifo_data_o),
        .rfifo_full_i (rfifo_full_i),
        .wfifo_pop_o  (wfifo_pop_o),
        .wfifo_data_i (wfifo_data_i),
        .wfifo_empty_i(wfifo_empty_i)
    );

    always #5 clk_i = ~clk_i;

    int          total = 0, bad = 0, cyc = 0, d0 = 0;
    int          done_cnt = 0, done_cyc = 0, push_cnt = 0, pop_cnt = 0;
    int          psel_cycles = 0, first_psel = -1, last_psel = -1;
    int          wait_cfg = 0, acc_cnt = 0;
    logic [31:0] err_addr = 32'h7777_7777;
    beat_t       exp_beat_q[$];
    logic [31:0] exp_push_q[$];
    logic        exp_done_q[$];
    logic [31:0] wq[$];
    beat_t       mon_b;
    logic        mon_e, pop_now;

    function automatic logic [31:0] rdv(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_beat(input logic wr, input logic [31:0] a, input logic [31:0] wd);
        beat_t b;
        b.wr = wr; b.addr = a; b.wdata = wd;
        exp_beat_q.push_back(b);
    endtask

    task automatic launch(input logic rw, input logic [31:0] a, input logic [7:0] nb, output int n);
        @(negedge clk_i);
        rw_i = rw; start_addr_i = a; num_bytes_i = nb; start_i = 1'b1;
        n = cyc; d0 = done_cnt;
        first_psel = -1; last_psel = -1; psel_cycles = 0;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int t = 0;
        while (done_cnt == d0 && t < bound) begin
            @(negedge clk_i); #2;
            t++;
        end
        total++;
        if (done_cnt == d0) begin
            bad++;
            $display("FAIL %s_timeout: got no done after %0d cycles, required one done", name, bound);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // APB slave: wait_cfg wait states per beat, error on err_addr
    always @(negedge clk_i) begin
        if (apb.psel_o && apb.penable_o) begin
            apb.pready_i  = (acc_cnt >= wait_cfg);
            apb.pslverr_i = apb.pready_i && (apb.paddr_o == err_addr);
            acc_cnt++;
        end else begin
            apb.pready_i  = 1'b0;
            apb.pslverr_i = 1'b0;
            acc_cnt = 0;
        end
        apb.prdata_i = rdv(apb.paddr_o);
    end

    // write FIFO, first-word fall-through, advances after the popping edge
    always @(posedge clk_i) begin
        pop_now = wfifo_pop_o;
        #1;
        if (pop_now) begin
            pop_cnt++;
            if (wq.size() > 0) void'(wq.pop_front());
        end
        wfifo_empty_i = (wq.size() == 0);
        wfifo_data_i  = (wq.size() > 0) ? wq[0] : 32'h0;
    end

    // monitor: compares every DUT presentation against the scoreboard queues
    always @(negedge clk_i) begin
        #1;
        if (!rst_i) begin
            if (apb.psel_o) begin
                psel_cycles++;
                if (first_psel < 0) first_psel = cyc;
                last_psel = cyc;
                if (exp_beat_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_psel: got access at addr %0h, required no APB access", apb.paddr_o);
                end else begin
                    mon_b = exp_beat_q[0];
                    check("apb_beat",
                          128'({apb.pwrite_o, apb.pstrb_o, apb.paddr_o, (mon_b.wr ? apb.pwdata_o : 32'h0)}),
                          128'({mon_b.wr, 4'hF, mon_b.addr, mon_b.wdata}));
                    if (apb.penable_o && apb.pready_i) void'(exp_beat_q.pop_front());
                end
            end else begin
                check("apb_idle", 128'({apb.penable_o, apb.pwrite_o, apb.pstrb_o}), 128'(0));
            end
            if (rfifo_push_o) begin
                push_cnt++;
                if (exp_push_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_push: got data %0h, required no push", rfifo_data_o);
                end else begin
                    check("rfifo_data", 128'(rfifo_data_o), 128'(exp_push_q.pop_front()));
                end
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
                if (exp_done_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done with err %0b, required no done", err_o);
                end else begin
                    mon_e = exp_done_q.pop_front();
                    check("done_err_busy", 128'({err_o, busy_o}), 128'({mon_e, 1'b0}));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, required test end");
        $fatal(1);
    end

    initial begin
        int n, p0, q0, dk;
        rst_i = 1'b1; start_i = 1'b0; rw_i = 1'b0; start_addr_i = '0; num_bytes_i = '0;
        rfifo_full_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #2;
        check("reset_ctrl", 128'({busy_o, done_o, err_o, apb.psel_o, apb.penable_o, apb.pwrite_o,
                                  rfifo_push_o, wfifo_pop_o}), 128'(0));
        check("reset_addr", 128'(apb.paddr_o), 128'(0));
        check("reset_data", 128'({apb.pwdata_o, apb.pstrb_o}), 128'(0));
        @(negedge clk_i); rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // 16-byte read, zero-wait slave
        wait_cfg = 0;
        add_beat(1'b0, 32'h0000_1000, 32'h0); add_beat(1'b0, 32'h0000_1004, 32'h0);
        add_beat(1'b0, 32'h0000_1008, 32'h0); add_beat(1'b0, 32'h0000_100C, 32'h0);
        exp_push_q.push_back(32'hC0DE_1000); exp_push_q.push_back(32'hC0DE_1004);
        exp_push_q.push_back(32'hC0DE_1008); exp_push_q.push_back(32'hC0DE_100C);
        exp_done_q.push_back(1'b0);
        p0 = push_cnt;
        launch(1'b1, 32'h0000_1000, 8'd16, n);
        wait_done("rd16", 40);
        check("rd16_first_psel", 128'(first_psel), 128'(n + 1));
        check("rd16_last_psel", 128'(last_psel), 128'(n + 8));
        check("rd16_done_cyc", 128'(done_cyc), 128'(n + 9));
        check("rd16_pushes", 128'(push_cnt - p0), 128'(4));

        // 8-byte write, 3 wait states per beat
        wait_cfg = 3;
        wq.push_back(32'hAAAA_0001); wq.push_back(32'hBBBB_0002);
        @(negedge clk_i);
        add_beat(1'b1, 32'h0000_2000, 32'hAAAA_0001);
        add_beat(1'b1, 32'h0000_2004, 32'hBBBB_0002);
        exp_done_q.push_back(1'b0);
        q0 = pop_cnt;
        launch(1'b0, 32'h0000_2000, 8'd8, n);
        wait_done("wr8", 60);
        check("wr8_pops", 128'(pop_cnt - q0), 128'(2));
        check("wr8_psel_cycles", 128'(psel_cycles), 128'(10));
        check("wr8_done_cyc", 128'(done_cyc), 128'(n + 11));

        // read stalled 5 cycles by a full read FIFO before beat 2
        wait_cfg = 0;
        add_beat(1'b0, 32'h0000_3000, 32'h0); add_beat(1'b0, 32'h0000_3004, 32'h0);
        add_beat(1'b0, 32'h0000_3008, 32'h0); add_beat(1'b0, 32'h0000_300C, 32'h0);
        exp_push_q.push_back(32'hC0DE_3000); exp_push_q.push_back(32'hC0DE_3004);
        exp_push_q.push_back(32'hC0DE_3008); exp_push_q.push_back(32'hC0DE_300C);
        exp_done_q.push_back(1'b0);
        p0 = push_cnt;
        launch(1'b1, 32'h0000_3000, 8'd16, n);
        @(negedge clk_i); rfifo_full_i = 1'b1;
        repeat (5) @(negedge clk_i);
        rfifo_full_i = 1'b0;
        wait_done("stall", 40);
        check("stall_psel_cycles", 128'(psel_cycles), 128'(8));
        check("stall_done_cyc", 128'(done_cyc), 128'(n + 14));
        check("stall_pushes", 128'(push_cnt - p0), 128'(4));

        // slave error on beat 2 of 4
        err_addr = 32'h0000_4004;
        add_beat(1'b0, 32'h0000_4000, 32'h0); add_beat(1'b0, 32'h0000_4004, 32'h0);
        exp_push_q.push_back(32'hC0DE_4000);
        exp_done_q.push_back(1'b1);
        p0 = push_cnt;
        launch(1'b1, 32'h0000_4000, 8'd16, n);
        wait_done("slverr", 40);
        repeat (4) @(negedge clk_i);
        #2;
        check("slverr_sticky", 128'({err_o, busy_o}), 128'(2'b10));
        check("slverr_psel_cycles", 128'(psel_cycles), 128'(4));
        check("slverr_pushes", 128'(push_cnt - p0), 128'(1));
        err_addr = 32'h7777_7777;

        // 3 bytes -> zero beats; also clears the sticky error
        exp_done_q.push_back(1'b0);
        launch(1'b1, 32'h0000_5000, 8'd3, n);
        wait_done("zero", 10);
        check("zero_done_cyc", 128'(done_cyc), 128'(n + 1));
        check("zero_psel_cycles", 128'(psel_cycles), 128'(0));
        check("zero_err_cleared", 128'(err_o), 128'(0));

        // address wrap
        add_beat(1'b0, 32'hFFFF_FFFC, 32'h0); add_beat(1'b0, 32'h0000_0000, 32'h0);
        exp_push_q.push_back(32'h3F21_FFFC); exp_push_q.push_back(32'hC0DE_0000);
        exp_done_q.push_back(1'b0);
        launch(1'b1, 32'hFFFF_FFFC, 8'd8, n);
        wait_done("wrap", 40);
        check("wrap_psel_cycles", 128'(psel_cycles), 128'(4));

        // reset during ACCESS with start held high
        wait_cfg = 3;
        add_beat(1'b0, 32'h0000_6000, 32'h0);
        launch(1'b1, 32'h0000_6000, 8'd16, n);
        @(negedge clk_i); #2;
        check("pre_rst_access", 128'({apb.psel_o, apb.penable_o}), 128'(2'b11));
        dk = done_cnt;
        start_i = 1'b1;
        rst_i = 1'b1;
        #1;
        check("rst_outputs", 128'({busy_o, done_o, err_o, apb.psel_o, apb.penable_o, apb.pwrite_o,
                                   rfifo_push_o, wfifo_pop_o, apb.pstrb_o}), 128'(0));
        check("rst_addr", 128'(apb.paddr_o), 128'(0));
        exp_beat_q.delete();
        psel_cycles = 0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (6) @(negedge clk_i);
        #2;
        check("rst_no_relaunch", 128'({busy_o, psel_cycles}), 128'(0));
        check("rst_no_done", 128'(done_cnt), 128'(dk));

        // fresh edge after reset launches normally
        start_i = 1'b0;
        wait_cfg = 0;
        add_beat(1'b0, 32'h0000_7000, 32'h0);
        exp_push_q.push_back(32'hC0DE_7000);
        exp_done_q.push_back(1'b0);
        launch(1'b1, 32'h0000_7000, 8'd4, n);
        wait_done("post_rst", 20);
        check("post_rst_done_cyc", 128'(done_cyc), 128'(n + 3));

        repeat (3) @(negedge clk_i);
        #2;
        check("queues_empty", 128'(exp_beat_q.size() + exp_push_q.size() + exp_done_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
